// File: rtl/led_breath_ctrl.sv
// Breathing-LED duty sequencer: ramps duty between min and max with holds at each end.
// Duty, state and the step/hold counters change only on PWM period wraps.
module led_breath_ctrl #(
  parameter int DUTY_BITS    = 8,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DUTY_BITS-1:0] cfg_min,
  input  logic [DUTY_BITS-1:0] cfg_max,
  output logic [DUTY_BITS-1:0] duty,
  output logic [2:0]           state_o,
  output logic                 cycle_done
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t               state_reg;
  logic [DUTY_BITS-1:0] pcnt_reg;
  logic [DUTY_BITS-1:0] min_reg;
  logic [DUTY_BITS-1:0] max_reg;
  logic [DUTY_BITS-1:0] duty_reg;
  logic [SW-1:0]        step_cnt_reg;
  logic [HW-1:0]        hold_cnt_reg;
  logic                 cycle_done_reg;

  logic wrap;
  logic step_tick;
  logic hold_last;

  assign wrap      = &pcnt_reg;
  assign step_tick = (step_cnt_reg == STEP_LAST);
  assign hold_last = (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pcnt_reg       <= '0;
      min_reg        <= '0;
      max_reg        <= '1;
      duty_reg       <= '0;
      step_cnt_reg   <= '0;
      hold_cnt_reg   <= '0;
      cycle_done_reg <= 1'b0;
    end else begin
      pcnt_reg       <= pcnt_reg + 1'b1;
      cycle_done_reg <= 1'b0;

      // A transfer on a wrap edge lands after the IDLE action below reads min_reg.
      if (cfg_valid && (state_reg == IDLE)) begin
        if (cfg_min <= cfg_max) begin
          min_reg <= cfg_min;
          max_reg <= cfg_max;
        end else begin
          min_reg <= cfg_max;
          max_reg <= cfg_min;
        end
      end

      if (wrap) begin
        case (state_reg)
          IDLE: begin
            duty_reg <= min_reg;
            if (en) begin
              state_reg    <= UP;
              step_cnt_reg <= '0;
            end
          end
          UP: begin
            if (step_tick) begin
              step_cnt_reg <= '0;
              if (duty_reg >= max_reg) begin
                state_reg    <= HOLD_HI;
                hold_cnt_reg <= '0;
              end else begin
                duty_reg <= duty_reg + 1'b1;
              end
            end else begin
              step_cnt_reg <= step_cnt_reg + 1'b1;
            end
          end
          HOLD_HI: begin
            if (hold_last) begin
              state_reg    <= DOWN;
              step_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          DOWN: begin
            if (step_tick) begin
              step_cnt_reg <= '0;
              if (duty_reg <= min_reg) begin
                state_reg    <= HOLD_LO;
                hold_cnt_reg <= '0;
              end else begin
                duty_reg <= duty_reg - 1'b1;
              end
            end else begin
              step_cnt_reg <= step_cnt_reg + 1'b1;
            end
          end
          HOLD_LO: begin
            if (hold_last) begin
              cycle_done_reg <= 1'b1;
              step_cnt_reg   <= '0;
              state_reg      <= en ? UP : IDLE;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign cfg_ready  = (state_reg == IDLE);
  assign duty       = duty_reg;
  assign state_o    = state_reg;
  assign cycle_done = cycle_done_reg;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Bench for led_breath_ctrl: closed-form breath-profile model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_led_breath_ctrl;

  localparam int DB = 4;
  localparam int S  = 2;
  localparam int H  = 3;
  localparam int P  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DB-1:0] cfg_min;
  logic [DB-1:0] cfg_max;
  logic [DB-1:0] duty;
  logic [2:0]    state_o;
  logic          cycle_done;

  led_breath_ctrl #(.DUTY_BITS(DB), .STEP_PERIODS(S), .HOLD_PERIODS(H)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .duty(duty), .state_o(state_o),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: when active, the profile is a pure function of k = periods since UP entry.
  bit m_valid = 1'b0;
  bit m_idle;
  bit m_done;
  bit pre_idle;
  int m_pc, m_k, m_min, m_max, m_duty, pre_min;

  function automatic int cyc_len();
    return 2 * (m_max - m_min + 1) * S + 2 * H;
  endfunction

  function automatic void exp_out(output int st, output int du);
    int r;
    r = (m_max - m_min + 1) * S;
    if (m_idle) begin
      st = 0; du = m_duty;
    end else if (m_k < r) begin
      st = 1; du = m_min + m_k / S;
    end else if (m_k < r + H) begin
      st = 2; du = m_max;
    end else if (m_k < 2 * r + H) begin
      st = 3; du = m_max - (m_k - r - H) / S;
    end else begin
      st = 4; du = m_min;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_pc = 0; m_idle = 1'b1; m_k = 0;
      m_min = 0; m_max = P - 1; m_duty = 0; m_done = 1'b0;
    end else if (m_valid) begin
      pre_idle = m_idle;
      pre_min  = m_min;
      m_done   = 1'b0;
      if (m_pc == P - 1) begin
        if (m_idle) begin
          m_duty = pre_min;
          if (en) begin m_idle = 1'b0; m_k = 0; end
        end else begin
          m_k++;
          if (m_k == cyc_len()) begin
            m_done = 1'b1;
            m_k    = 0;
            if (!en) begin m_idle = 1'b1; m_duty = m_min; end
          end
        end
      end
      if (cfg_valid && pre_idle) begin
        m_min = (cfg_min < cfg_max) ? int'(cfg_min) : int'(cfg_max);
        m_max = (cfg_min < cfg_max) ? int'(cfg_max) : int'(cfg_min);
        $display("cfg transfer: min=%0d max=%0d at %0t", m_min, m_max, $time);
      end
      m_pc = (m_pc + 1) % P;
    end
  end

  always @(negedge clk) begin
    int es, ed;
    if (m_valid) begin
      exp_out(es, ed);
      check("model_duty", int'(duty), ed);
      check("model_state", int'(state_o), es);
      check("model_cfg_ready", int'(cfg_ready), int'(es == 0));
      check("model_cycle_done", int'(cycle_done), int'(m_done));
    end
  end

  int dmin, dmax;

  task automatic wait_done(input string name, input int budget, output int n);
    int found;
    n = 0; found = 0; dmin = 255; dmax = -1;
    while (found == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (int'(duty) < dmin) dmin = int'(duty);
      if (int'(duty) > dmax) dmax = int'(duty);
      if (cycle_done) found = 1;
    end
    check(name, found, 1);
    if (found != 0) $display("cycle_done after %0d clocks, duty range %0d..%0d", n, dmin, dmax);
  endtask

  task automatic wait_state(input string name, input int st, input int budget);
    int n = 0;
    while (int'(state_o) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_o), st);
  endtask

  task automatic load_cfg(input int a, input int b);
    cfg_min = DB'(a); cfg_max = DB'(b); cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_min = '0; cfg_max = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_duty", int'(duty), 0);
    check("rst_state", int'(state_o), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_cycle_done", int'(cycle_done), 0);
    repeat (64) @(negedge clk);
    check("idle_duty", int'(duty), 0);

    // Normal 2..5 breathing
    load_cfg(2, 5);
    en = 1'b1;
    wait_state("t2_enter_up", 1, 64);
    check("t2_first_duty", int'(duty), 2);
    wait_done("t2_pulse_a", 1000, n);
    check("t2_state_after_pulse", int'(state_o), 1);
    wait_done("t2_pulse_b", 1000, n);
    check("t2_period", n, 352);
    check("t2_dmax", dmax, 5);
    check("t2_dmin", dmin, 2);

    // Graceful stop from UP
    en = 1'b0;
    wait_done("t5_pulse", 1000, n);
    check("t5_period", n, 352);
    check("t5_state_idle", int'(state_o), 0);
    check("t5_duty_min", int'(duty), 2);
    repeat (40) @(negedge clk);
    check("t5_still_idle", int'(state_o), 0);

    // Swapped config, and config offers ignored while active
    load_cfg(9, 6);
    en = 1'b1;
    wait_state("t3_enter_up", 1, 64);
    check("t3_first_duty", int'(duty), 6);
    cfg_min = 4'd0; cfg_max = 4'd15; cfg_valid = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_cfg_ready_busy", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    wait_done("t3_pulse_a", 1000, n);
    wait_done("t3_pulse_b", 1000, n);
    check("t3_period", n, 352);
    check("t3_dmax", dmax, 9);
    check("t3_dmin", dmin, 6);
    en = 1'b0;
    wait_done("t3_stop_pulse", 1000, n);
    check("t3_state_idle", int'(state_o), 0);

    // Equal bounds, loaded exactly on a wrap edge: old min applies for one more period
    n = 0;
    while (m_pc != P - 1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    load_cfg(7, 7);
    check("t4_old_min_on_wrap", int'(duty), 6);
    repeat (P) @(negedge clk);
    check("t4_new_min_next_wrap", int'(duty), 7);
    en = 1'b1;
    wait_done("t4_pulse_a", 1000, n);
    wait_done("t4_pulse_b", 1000, n);
    check("t4_period", n, 160);
    check("t4_dmax", dmax, 7);
    check("t4_dmin", dmin, 7);

    // Reset in the middle of DOWN at duty 4
    en = 1'b0;
    wait_done("t6_stop_pulse", 1000, n);
    load_cfg(2, 5);
    en = 1'b1;
    n = 0;
    while (!(state_o == 3'd3 && duty == 4'd4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_down4", int'(duty), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_duty", int'(duty), 0);
    check("t6_rst_state", int'(state_o), 0);
    check("t6_rst_cfg_ready", int'(cfg_ready), 1);
    wait_done("t6_pulse_a", 2000, n);
    wait_done("t6_pulse_b", 2000, n);
    check("t6_period", n, 1120);
    check("t6_dmax", dmax, 15);
    check("t6_dmin", dmin, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
